// File: rtl/axis_frame_len_stats.sv
// axis_frame_len_stats: per-period frame length statistics with snapshot/clear; FRAME_LEN_STATS_HIST_EN adds stat_hist0..3 | ports: clk, rst, frame_len/frame_len_valid in, snap_req/snap_clear in, stat_valid + stat_* snapshot out
module axis_frame_len_stats #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32,
  parameter int SUM_WIDTH = 48,
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 frame_len_valid,
  input  logic                 snap_req,
  input  logic                 snap_clear,
  output logic                 stat_valid,
  output logic [CNT_WIDTH-1:0] stat_frames,
  output logic [SUM_WIDTH-1:0] stat_bytes,
  output logic [LEN_WIDTH-1:0] stat_min,
  output logic [LEN_WIDTH-1:0] stat_max,
  output logic [CNT_WIDTH-1:0] stat_runt,
  output logic [CNT_WIDTH-1:0] stat_oversize
`ifdef FRAME_LEN_STATS_HIST_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_hist0,
  output logic [CNT_WIDTH-1:0] stat_hist1,
  output logic [CNT_WIDTH-1:0] stat_hist2,
  output logic [CNT_WIDTH-1:0] stat_hist3
`endif
);
  localparam logic [LEN_WIDTH-1:0] L_MIN = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] L_MAX = LEN_WIDTH'(MAX_LEN);
  logic [CNT_WIDTH-1:0] r_frames, r_runt, r_over, w_frames, w_runt, w_over;
  logic [SUM_WIDTH-1:0] r_bytes, w_bytes;
  logic [SUM_WIDTH:0]   w_sum;
  logic [LEN_WIDTH-1:0] r_min, r_max, w_min, w_max;
  logic                 w_clr;
  function automatic logic [CNT_WIDTH-1:0] inc(input logic [CNT_WIDTH-1:0] v, input logic en);
    return (en && v != '1) ? v + CNT_WIDTH'(1) : v;
  endfunction
  // w_* is the live state including this cycle's frame; it feeds both the live update and the snapshot
  always_comb begin
    w_sum    = {1'b0, r_bytes} + (SUM_WIDTH+1)'(frame_len);
    w_frames = inc(r_frames, frame_len_valid);
    w_bytes  = !frame_len_valid ? r_bytes : w_sum[SUM_WIDTH] ? '1 : w_sum[SUM_WIDTH-1:0];
    w_min    = (frame_len_valid && frame_len < r_min) ? frame_len : r_min;
    w_max    = (frame_len_valid && frame_len > r_max) ? frame_len : r_max;
    w_runt   = inc(r_runt, frame_len_valid && frame_len < L_MIN);
    w_over   = inc(r_over, frame_len_valid && frame_len > L_MAX);
    w_clr    = snap_req && snap_clear;
  end
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_frames <= '0;
      r_bytes  <= '0;
      r_min    <= '1;
      r_max    <= '0;
      r_runt   <= '0;
      r_over   <= '0;
    end else begin
      r_frames <= w_frames;
      r_bytes  <= w_bytes;
      r_min    <= w_min;
      r_max    <= w_max;
      r_runt   <= w_runt;
      r_over   <= w_over;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_valid    <= 1'b0;
      stat_frames   <= '0;
      stat_bytes    <= '0;
      stat_min      <= '0;
      stat_max      <= '0;
      stat_runt     <= '0;
      stat_oversize <= '0;
    end else begin
      stat_valid <= snap_req;
      if (snap_req) begin
        stat_frames   <= w_frames;
        stat_bytes    <= w_bytes;
        stat_min      <= (w_frames == '0) ? '0 : w_min;
        stat_max      <= w_max;
        stat_runt     <= w_runt;
        stat_oversize <= w_over;
      end
    end
  end
`ifdef FRAME_LEN_STATS_HIST_EN
  logic [CNT_WIDTH-1:0] r_hist [4];
  logic [CNT_WIDTH-1:0] w_hist [4];
  logic [3:0]           w_bin;
  always_comb begin
    w_bin[0] = frame_len >= L_MIN && frame_len <= LEN_WIDTH'(127);
    w_bin[1] = frame_len >= LEN_WIDTH'(128) && frame_len <= LEN_WIDTH'(511);
    w_bin[2] = frame_len >= LEN_WIDTH'(512) && frame_len <= LEN_WIDTH'(1023);
    w_bin[3] = frame_len >= LEN_WIDTH'(1024) && frame_len <= L_MAX;
    for (int i = 0; i < 4; i++) w_hist[i] = inc(r_hist[i], frame_len_valid && w_bin[i]);
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) r_hist[i] <= (rst || w_clr) ? '0 : w_hist[i];
    if (rst) begin
      stat_hist0 <= '0;
      stat_hist1 <= '0;
      stat_hist2 <= '0;
      stat_hist3 <= '0;
    end else if (snap_req) begin
      stat_hist0 <= w_hist[0];
      stat_hist1 <= w_hist[1];
      stat_hist2 <= w_hist[2];
      stat_hist3 <= w_hist[3];
    end
  end
`endif
endmodule
